// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec
//  Description : 8080 execute sequencer; drives ALU operands/enables and
//                captures result and flags into ACC, result register and PSW.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec #(
    parameter logic [7:0] PSW_RST = 8'h02
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_op_i,
    input  logic [7:0] req_opnd_i,
    input  logic       req_cmp_i,
    input  logic       acc_load_i,
    input  logic [7:0] acc_dat_i,
    input  logic       psw_load_i,
    input  logic [7:0] psw_dat_i,
    output logic [7:0] a_dat_o,
    output logic [7:0] b_dat_o,
    output logic [3:0] alu_sel_o,
    output logic       alu_out_o,
    output logic       flag_out_o,
    input  logic [7:0] alu_dat_i,
    input  logic [3:0] flag_i,
    output logic [7:0] acc_o,
    output logic [7:0] res_dat_o,
    output logic [7:0] psw_o,
    output logic       cy_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CAPT  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_acc;
    logic [7:0] r_res;
    logic [7:0] r_psw;
    logic [7:0] r_opnd;
    logic [3:0] r_op;
    logic       r_cmp;
    logic       r_en;
    logic       r_done;

    logic       w_z;
    logic       w_s;
    logic       w_p;
    logic       w_cy;
    logic       w_acc_wr;
    logic       w_res_wr;
    logic [7:0] w_psw_new;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid_i) w_state_nxt = ST_DRIVE;
            ST_DRIVE: w_state_nxt = ST_CAPT;
            ST_CAPT:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU flag bus is {nonzero, sign, odd-parity, carry}; PSW wants Z and even P
    assign w_z  = ~flag_i[3];
    assign w_s  = flag_i[2];
    assign w_p  = ~flag_i[1];
    assign w_cy = flag_i[0];

    // PSW layout {S, Z, 0, AC, 0, P, 1, CY}; AC is only ever carried through
    always_comb begin
        w_acc_wr  = 1'b0;
        w_res_wr  = 1'b1;
        w_psw_new = r_psw;
        case (r_op)
            4'h0, 4'h1: begin
                w_psw_new = {w_s, w_z, 1'b0, r_psw[4], 1'b0, w_p, 1'b1, r_psw[0]};
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
                w_psw_new = {w_s, w_z, 1'b0, r_psw[4], 1'b0, w_p, 1'b1, w_cy};
                w_acc_wr  = ~r_cmp;
            end
            4'h6, 4'h7, 4'h8: begin
                w_psw_new = {w_s, w_z, 1'b0, r_psw[4], 1'b0, w_p, 1'b1, 1'b0};
                w_acc_wr  = ~r_cmp;
            end
            4'h9, 4'hA, 4'hB, 4'hC: begin
                w_psw_new = {r_psw[7:1], w_cy};
                w_acc_wr  = 1'b1;
            end
            4'hD: begin
                w_acc_wr  = 1'b1;
            end
            default: begin
                w_psw_new = {r_psw[7:1], w_cy};
                w_res_wr  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc  <= 8'h00;
            r_res  <= 8'h00;
            r_psw  <= PSW_RST;
            r_opnd <= 8'h00;
            r_op   <= 4'h0;
            r_cmp  <= 1'b0;
            r_en   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_en   <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (acc_load_i) begin
                        r_acc <= acc_dat_i;
                    end
                    if (psw_load_i) begin
                        r_psw <= {psw_dat_i[7:6], 1'b0, psw_dat_i[4], 1'b0,
                                  psw_dat_i[2], 1'b1, psw_dat_i[0]};
                    end
                    if (req_valid_i) begin
                        r_op   <= req_op_i;
                        r_opnd <= req_opnd_i;
                        r_cmp  <= req_cmp_i;
                    end
                end
                ST_CAPT: begin
                    r_done <= 1'b1;
                    r_psw  <= w_psw_new;
                    if (w_acc_wr) begin
                        r_acc <= alu_dat_i;
                    end
                    if (w_res_wr) begin
                        r_res <= alu_dat_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o = (r_state == ST_IDLE) && !rst_i;
    assign a_dat_o     = r_acc;
    assign b_dat_o     = r_opnd;
    assign alu_sel_o   = r_op;
    assign alu_out_o   = r_en;
    assign flag_out_o  = r_en;
    assign acc_o       = r_acc;
    assign res_dat_o   = r_res;
    assign psw_o       = r_psw;
    assign cy_o        = r_psw[0];
    assign done_o      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec
//  Description : Scoreboard bench for alu_exec with directed ALU vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [3:0] req_op_i;
    logic [7:0] req_opnd_i;
    logic       req_cmp_i;
    logic       acc_load_i;
    logic [7:0] acc_dat_i;
    logic       psw_load_i;
    logic [7:0] psw_dat_i;
    logic [7:0] a_dat_o;
    logic [7:0] b_dat_o;
    logic [3:0] alu_sel_o;
    logic       alu_out_o;
    logic       flag_out_o;
    logic [7:0] alu_dat_i;
    logic [3:0] flag_i;
    logic [7:0] acc_o;
    logic [7:0] res_dat_o;
    logic [7:0] psw_o;
    logic       cy_o;
    logic       done_o;

    alu_exec #(.PSW_RST(8'h02)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_opnd_i  (req_opnd_i),
        .req_cmp_i   (req_cmp_i),
        .acc_load_i  (acc_load_i),
        .acc_dat_i   (acc_dat_i),
        .psw_load_i  (psw_load_i),
        .psw_dat_i   (psw_dat_i),
        .a_dat_o     (a_dat_o),
        .b_dat_o     (b_dat_o),
        .alu_sel_o   (alu_sel_o),
        .alu_out_o   (alu_out_o),
        .flag_out_o  (flag_out_o),
        .alu_dat_i   (alu_dat_i),
        .flag_i      (flag_i),
        .acc_o       (acc_o),
        .res_dat_o   (res_dat_o),
        .psw_o       (psw_o),
        .cy_o        (cy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] acc;
        logic [7:0] res;
        logic [7:0] psw;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest pending expectation
    always @(negedge clk_i) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc", {24'd0, acc_o}, {24'd0, e.acc});
                chk("res", {24'd0, res_dat_o}, {24'd0, e.res});
                chk("psw", {24'd0, psw_o}, {24'd0, e.psw});
                chk("cy", {31'd0, cy_o}, {31'd0, e.psw[0]});
                chk("latency", cyc - e.cyc, 32'd3);
                chk("bus_released", {30'd0, alu_out_o, flag_out_o}, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        if (sb.size() != 0) chk("done_timeout", sb.size(), 32'd0);
    endtask

    task automatic load(input logic al, input logic [7:0] ad, input logic pl, input logic [7:0] pd);
        wait_ready();
        acc_load_i = al;
        acc_dat_i  = ad;
        psw_load_i = pl;
        psw_dat_i  = pd;
        @(posedge clk_i);
        #1;
        acc_load_i = 1'b0;
        psw_load_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] opnd, input logic cmp,
                         input logic [7:0] alu, input logic [3:0] flg,
                         input logic ld, input logic [7:0] ld_dat, input logic push,
                         input logic [7:0] ea, input logic [7:0] er, input logic [7:0] ep);
        exp_t e;
        wait_ready();
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_opnd_i  = opnd;
        req_cmp_i   = cmp;
        alu_dat_i   = alu;
        flag_i      = flg;
        acc_load_i  = ld;
        acc_dat_i   = ld_dat;
        if (push) begin
            e.acc = ea;
            e.res = er;
            e.psw = ep;
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        acc_load_i  = 1'b0;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] opnd, input logic cmp,
                         input logic [7:0] alu, input logic [3:0] flg,
                         input logic ld, input logic [7:0] ld_dat,
                         input logic [7:0] ea, input logic [7:0] er, input logic [7:0] ep,
                         input logic [7:0] exp_a, input logic junk);
        issue(op, opnd, cmp, alu, flg, ld, ld_dat, 1'b1, ea, er, ep);
        @(negedge clk_i);
        chk("drive_a", {24'd0, a_dat_o}, {24'd0, exp_a});
        chk("drive_b", {24'd0, b_dat_o}, {24'd0, opnd});
        chk("drive_sel", {28'd0, alu_sel_o}, {28'd0, op});
        chk("drive_en", {30'd0, alu_out_o, flag_out_o}, 32'd3);
        if (junk) begin
            // A direct load while the op is in flight must be dropped
            acc_load_i = 1'b1;
            acc_dat_i  = 8'h55;
            @(posedge clk_i);
            #1;
            acc_load_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = 4'h0;
        req_opnd_i  = 8'h00;
        req_cmp_i   = 1'b0;
        acc_load_i  = 1'b0;
        acc_dat_i   = 8'h00;
        psw_load_i  = 1'b0;
        psw_dat_i   = 8'h00;
        alu_dat_i   = 8'h00;
        flag_i      = 4'h0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst_acc", {24'd0, acc_o}, 32'h00);
        chk("rst_res", {24'd0, res_dat_o}, 32'h00);
        chk("rst_psw", {24'd0, psw_o}, 32'h02);
        chk("rst_b", {24'd0, b_dat_o}, 32'h00);
        chk("rst_sel", {28'd0, alu_sel_o}, 32'h0);
        chk("rst_en", {30'd0, alu_out_o, flag_out_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("ready_after_rst", {31'd0, req_ready_o}, 32'd1);

        // ADD with zero result and carry out
        load(1'b1, 8'h3C, 1'b0, 8'h00);
        chk("load_acc", {24'd0, acc_o}, 32'h3C);
        do_op(4'h2, 8'hC4, 1'b0, 8'h00, 4'b0001, 1'b0, 8'h00, 8'h00, 8'h00, 8'h47, 8'h3C, 1'b0);

        // Simultaneous ACC and PSW loads, then AND clears CY; then AND as compare
        load(1'b1, 8'hF0, 1'b1, 8'h01);
        chk("load_both_acc", {24'd0, acc_o}, 32'hF0);
        chk("load_both_psw", {24'd0, psw_o}, 32'h03);
        do_op(4'h6, 8'h3C, 1'b0, 8'h30, 4'b1000, 1'b0, 8'h00, 8'h30, 8'h30, 8'h06, 8'hF0, 1'b0);
        load(1'b1, 8'hF0, 1'b0, 8'h00);
        do_op(4'h6, 8'h3C, 1'b1, 8'h30, 4'b1000, 1'b0, 8'h00, 8'hF0, 8'h30, 8'h06, 8'hF0, 1'b0);

        // POP PSW with all ones: fixed bits forced, AC kept through a rotate (cmp ignored)
        load(1'b0, 8'h00, 1'b1, 8'hFF);
        chk("psw_fixed_bits", {24'd0, psw_o}, 32'hD7);
        do_op(4'h9, 8'h00, 1'b1, 8'hAB, 4'b0000, 1'b0, 8'h00, 8'hAB, 8'hAB, 8'hD6, 8'hF0, 1'b0);

        // INC keeps CY and ACC; stray ACC load during DRIVE dropped
        load(1'b0, 8'h00, 1'b1, 8'h01);
        do_op(4'h0, 8'h7F, 1'b0, 8'h80, 4'b1110, 1'b0, 8'h00, 8'hAB, 8'h80, 8'h83, 8'hAB, 1'b1);
        // back-to-back compare-form ADD
        do_op(4'h4, 8'h01, 1'b1, 8'h12, 4'b1001, 1'b0, 8'h00, 8'hAB, 8'h12, 8'h07, 8'hAB, 1'b0);

        // From reset: STC then CMC leave ACC/result untouched
        wait_idle();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        do_op(4'hF, 8'h00, 1'b0, 8'hEE, 4'b0001, 1'b0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 1'b0);
        do_op(4'hE, 8'h00, 1'b0, 8'hEE, 4'b0000, 1'b0, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 1'b0);

        // COMPLEMENT with a coincident ACC load operates on the loaded value
        do_op(4'hD, 8'h00, 1'b0, 8'hAA, 4'b0000, 1'b1, 8'h55, 8'hAA, 8'hAA, 8'h02, 8'h55, 1'b0);

        // Reset during CAPT aborts the ADD entirely
        wait_idle();
        load(1'b1, 8'h3C, 1'b0, 8'h00);
        issue(4'h2, 8'hC4, 1'b0, 8'h00, 4'b0001, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_acc", {24'd0, acc_o}, 32'h00);
        chk("abort_res", {24'd0, res_dat_o}, 32'h00);
        chk("abort_psw", {24'd0, psw_o}, 32'h02);
        chk("abort_b", {24'd0, b_dat_o}, 32'h00);
        chk("abort_en", {30'd0, alu_out_o, flag_out_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        chk("abort_ready_in_rst", {31'd0, req_ready_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_ready_after", {31'd0, req_ready_o}, 32'd1);
        chk("abort_no_done", {31'd0, done_o}, 32'd0);

        // Normal operation resumes after the abort
        do_op(4'h2, 8'h01, 1'b0, 8'h01, 4'b1000, 1'b0, 8'h00, 8'h01, 8'h01, 8'h06, 8'h00, 1'b0);

        wait_idle();
        repeat (3) @(negedge clk_i);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_exec.md
# alu_exec

Execute sequencer and flag/accumulator holder for the 8080 datapath, sitting directly upstream and downstream of the ALU. It accepts one ALU operation per request and drives the accumulator and a latched operand onto the ALU inputs. It sequences the ALU output enables, then captures the result and flag bus into the accumulator, result register and PSW. The instruction decoder issues requests; the register file and stack logic read `acc_o`, `res_dat_o` and `psw_o`.

## Interface
Parameters:
- `PSW_RST`, 8'h02: PSW value after reset.

Ports:
- `clk_i`  in  1  single clock; all state changes on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  operation request.
- `req_ready_o`  out  1  high in IDLE and not in reset.
- `req_op_i`  in  4  ALU select code, ALU encoding (0 INC … F STC).
- `req_opnd_i`  in  8  second operand; latched on accept.
- `req_cmp_i`  in  1  compare: update flags only, never accumulator.
- `acc_load_i`, `acc_dat_i`  in  1/8  direct accumulator write (MOV/MVI A).
- `psw_load_i`, `psw_dat_i`  in  1/8  direct PSW write (POP PSW).
- `a_dat_o`, `b_dat_o`  out  8/8  to ALU: accumulator, latched operand.
- `alu_sel_o`  out  4  to ALU select.
- `alu_out_o`, `flag_out_o`  out  1/1  ALU result/flag bus enables.
- `alu_dat_i`  in  8  ALU result bus.
- `flag_i`  in  4  ALU flag bus {nonzero, sign, odd-parity, carry}.
- `acc_o`, `res_dat_o`, `psw_o`  out  8/8/8  accumulator, last result, PSW.
- `cy_o`  out  1  PSW carry bit.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- PSW layout: {S, Z, 0, AC, 0, P, 1, CY}. Bits 5 and 3 are always 0 and bit 1 is always 1, including after `psw_load_i`.
- Flag conversion from `flag_i`:
  - Z = ~flag_i[3]
  - S = flag_i[2]
  - P = ~flag_i[1] (even parity)
  - CY = flag_i[0]
- AC is never computed. Only `psw_load_i` or reset changes it.
- FSM states IDLE → DRIVE → CAPT → IDLE.
  - IDLE: `req_ready_o`=1. Accept when `req_valid_i`; latch op, operand and cmp.
  - DRIVE: `alu_sel_o`=latched op; `alu_out_o`=`flag_out_o`=1.
  - CAPT: enables still high. Sample `alu_dat_i`/`flag_i` on the exit edge and update registers per the op class below. `done_o` is registered and goes high the following cycle, together with `req_ready_o`.
- Op classes (all captured results are written to `res_dat_o`):
  - INC, DEC (0,1): update Z S P. CY preserved. Accumulator not written.
  - ADD..SUB_BORROW (2–5): update Z S P CY. Accumulator written unless cmp.
  - AND, XOR, OR (6–8): update Z S P, CY := 0. Accumulator written unless cmp.
  - Rotates (9–C): update CY only. Accumulator written.
  - COMPLEMENT (D): no flags. Accumulator written.
  - CMC, STC (E,F): CY := flag_i[0]. Accumulator and `res_dat_o` unchanged.
- `req_cmp_i` is ignored for classes other than 2–8.
- Direct loads are honoured only in IDLE and are ignored in DRIVE/CAPT.
- A load coincident with request accept takes effect on the same edge, and the request then operates on the new value.
- `acc_load_i` and `psw_load_i` may occur together; both apply.

## Timing
- Reset values:
  - `acc_o`=0, `res_dat_o`=0, `psw_o`=PSW_RST, `b_dat_o`=0.
  - `alu_sel_o`=0, `alu_out_o`=0, `flag_out_o`=0, `done_o`=0.
  - State IDLE. `req_ready_o`=0 while `rst_i` is high.
- Latency: accept edge T0; DRIVE in cycle T0–T1; CAPT in T1–T2; registers update at T2; `done_o` high in T2–T3.
- Throughput: one op per 3 cycles back-to-back, with the next accept at T3.
- `alu_out_o`/`flag_out_o` are low in IDLE, so the buses are released.
- Outputs are registered except `req_ready_o`, which is decoded from state.
- Reset asserted mid-operation aborts the op with no register update and no `done_o` pulse.
- `req_valid_i` while not ready is ignored. The requester holds it until accepted.

## Test plan
- Accumulator 0x3C, ADD operand 0xC4, ALU returns 0x00/flag 4'b0001 → `acc_o`=0x00, `psw_o`=0x47, `done_o` pulse 3 cycles after accept.
- Accumulator 0xF0, CY=1, AND operand 0x3C, ALU returns 0x30/4'b1000 → `acc_o`=0x30, `psw_o`=0x06; same op with cmp → `acc_o` stays 0xF0, `psw_o`=0x06.
- CY=1, INC operand 0x7F, ALU returns 0x80/4'b1110 → `res_dat_o`=0x80, accumulator unchanged, `psw_o`=0x83.
- From reset, STC (flag 4'b0001) then CMC (4'b0000) → `cy_o` 1 then 0; `res_dat_o` stays 0x00; `psw_o` ends 0x02.
- `acc_load_i`=1 with 0x55 during DRIVE → ignored. The same load in IDLE coincident with a COMPLEMENT request → `a_dat_o`=0x55 in DRIVE.
- `rst_i` pulsed during CAPT of an ADD → all registers at reset values, no `done_o`, `req_ready_o`=1 the cycle after reset is released.
